// File: rtl/mdu.sv
// Iterative 32-cycle multiply/divide unit holding architectural HI/LO for the MIPS core.
// Define MDU_DIV_EN to build the restoring divider; without it DIV/DIVU are reserved opcodes.
module mdu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] OpA,
    input  logic [31:0] OpB,
    input  logic        Flush,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic        neg_q, neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
`ifdef MDU_DIV_EN
    logic        is_div_q, is_div_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div0_q, div0_d;
`endif

    logic        op_valid;
    logic        accept;
    logic        op_signed;
    logic        sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;
    logic [63:0] step_nxt;
    logic [63:0] prod;
    logic [31:0] res_hi, res_lo;
`ifdef MDU_DIV_EN
    logic [32:0] div_shift;
    logic [32:0] div_sub;
    logic        div_ge;
    logic [63:0] div_nxt;
    logic [31:0] quo, rem;
`endif

    always_comb begin
        op_valid = 1'b0;
        case (Op)
            OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO: op_valid = 1'b1;
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU:                     op_valid = 1'b1;
`endif
            default:                             op_valid = 1'b0;
        endcase
    end

    // Flush wins over Start in every state, including IDLE/DONE.
    assign accept    = (state_q != S_RUN) && Start && !Flush && op_valid;
    assign op_signed = (Op == OP_MULT) || (Op == OP_DIV);
    assign sign_a    = op_signed & OpA[31];
    assign sign_b    = op_signed & OpB[31];
    assign mag_a     = sign_a ? (32'd0 - OpA) : OpA;
    assign mag_b     = sign_b ? (32'd0 - OpB) : OpB;

    // Shift-add: multiplier sits in acc low half and shifts out as the product shifts in.
    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_nxt = {mul_sum, acc_q[31:1]};

`ifdef MDU_DIV_EN
    // Restoring divide: acc = {remainder, dividend/quotient}.
    assign div_shift = {acc_q[63:32], acc_q[31]};
    assign div_sub   = div_shift - {1'b0, opnd_q};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    assign div_nxt   = div_ge ? {div_sub[31:0], acc_q[30:0], 1'b1}
                              : {div_shift[31:0], acc_q[30:0], 1'b0};
    assign step_nxt  = is_div_q ? div_nxt : mul_nxt;
    assign quo       = step_nxt[31:0];
    assign rem       = step_nxt[63:32];
`else
    assign step_nxt  = mul_nxt;
`endif

    assign prod = neg_q ? (64'd0 - step_nxt) : step_nxt;

    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
`ifdef MDU_DIV_EN
        if (is_div_q) begin
            res_lo = div0_q ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - quo) : quo);
            res_hi = neg_rem_q ? (32'd0 - rem) : rem;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_d     = neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
`ifdef MDU_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (Op == OP_MTHI) begin
                        hi_d = OpA;
                    end else if (Op == OP_MTLO) begin
                        lo_d = OpA;
                    end else begin
                        state_d   = S_RUN;
                        cnt_d     = 6'd32;
                        acc_d     = {32'd0, mag_a};
                        opnd_d    = mag_b;
                        neg_d     = sign_a ^ sign_b;
`ifdef MDU_DIV_EN
                        is_div_d  = Op[1];
                        neg_rem_d = sign_a;
                        div0_d    = (OpB == 32'd0);
`endif
                    end
                end
            end
            S_RUN: begin
                if (Flush) begin
                    state_d = S_IDLE;
                    cnt_d   = 6'd0;
                end else begin
                    acc_d = step_nxt;
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        hi_d    = res_hi;
                        lo_d    = res_lo;
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            acc_q     <= 64'd0;
            opnd_q    <= 32'd0;
            neg_q     <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
`ifdef MDU_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            neg_q     <= neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
`ifdef MDU_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
`endif
        end
    end

    assign Busy = (state_q == S_RUN);
    assign Done = (state_q == S_DONE);
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed and random mul/div/mt traffic against an arithmetic model.
module tb_mdu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;
    logic [63:0] exp_q[$];

    mdu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Start (start),
        .Op    (op),
        .OpA   (opa),
        .OpB   (opb),
        .Flush (flush),
        .Busy  (busy),
        .Done  (done),
        .Hi    (hi),
        .Lo    (lo)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: {hi, lo} from plain arithmetic
    function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb;
        int ia, ib, iq, ir;
        logic [63:0] p;
        p = 64'd0;
        case (o)
            3'd0: begin
                ia = a; ib = b; sa = ia; sb = ib;
                p = sa * sb;
            end
            3'd1: p = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
                else begin
                    ia = a; ib = b; iq = ia / ib; ir = ia % ib;
                    p = {ir, iq};
                end
            end
            3'd3: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
            default: p = 64'd0;
        endcase
        return p;
    endfunction

    // driver: wait for Done after an accepted mul/div (called at negedge after E0)
    task automatic wait_done(input logic [31:0] h0, input logic [31:0] l0,
                             output int lat, output bit ok);
        lat = 0;
        ok  = 1'b1;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) break;
            if (busy !== 1'b1 || hi !== h0 || lo !== l0) ok = 1'b0;
        end
    endtask

    task automatic do_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input string name);
        int lat;
        bit ok;
        logic [63:0] e;
        exp_q.push_back(ref_md(o, a, b));
        op = o; opa = a; opb = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL %s busy after accept: got %b want 1", name, busy);
        end
        wait_done(mhi, mlo, lat, ok);
        e = exp_q.pop_front();
        total++;
        if (lat !== 32 || !ok) begin
            bad++; $display("FAIL %s latency/hold: got lat=%0d hold_ok=%0d want lat=32 hold_ok=1", name, lat, ok);
        end
        total++;
        if (hi !== e[63:32] || lo !== e[31:0] || busy !== 1'b0) begin
            bad++; $display("FAIL %s result a=%h b=%h: got hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0",
                            name, a, b, hi, lo, busy, e[63:32], e[31:0]);
        end
        mhi = e[63:32]; mlo = e[31:0];
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL %s done width: got done=%b want 0", name, done);
        end
    endtask

    task automatic do_mt(input logic [2:0] o, input logic [31:0] a, input string name);
        if (o == 3'd4) mhi = a; else mlo = a;
        op = o; opa = a; opb = $urandom; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (hi !== mhi || lo !== mlo || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL %s: got hi=%h lo=%h busy=%b done=%b want hi=%h lo=%h busy=0 done=0",
                            name, hi, lo, busy, done, mhi, mlo);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; opa = 32'd0; opb = 32'd0;
        repeat (3) @(negedge clk);
        total++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset: got hi=%h lo=%h busy=%b done=%b want all 0", hi, lo, busy, done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        do_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        do_md(3'd0, 32'hFFFF_FFFD, 32'd5, "mult_neg");
        do_mt(3'd4, 32'h1234_5678, "mthi_after_mult");
        do_md(3'd0, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
        do_md(3'd1, 32'd6, 32'd7, "multu_6x7");
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div();
        do_md(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
        do_md(3'd3, 32'd100, 32'd0, "divu_by_zero");
        do_md(3'd2, 32'hFFFF_FFF9, 32'd0, "div_neg_by_zero");
        do_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        do_md(3'd2, 32'd7, 32'hFFFF_FFFE, "div_7_neg2");
    endtask
`else
    task automatic test_no_div();
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo;
        for (int i = 2; i < 4; i++) begin
            op = 3'(i); opa = 32'd7; opb = 32'd2; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || hi !== h0 || lo !== l0) begin
                bad++; $display("FAIL nodiv op=%0d: got busy=%b done=%b hi=%h lo=%h want busy=0 done=0 hi=%h lo=%h",
                                i, busy, done, hi, lo, h0, l0);
            end
        end
        do_md(3'd1, 32'd6, 32'd7, "nodiv_multu");
    endtask
`endif

    task automatic test_reserved();
        for (int i = 6; i < 8; i++) begin
            op = 3'(i); opa = $urandom; opb = $urandom; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || hi !== mhi || lo !== mlo) begin
                bad++; $display("FAIL reserved op=%0d: got busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h",
                                i, busy, hi, lo, mhi, mlo);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        bit ok;
        logic [63:0] e;
`ifdef MDU_DIV_EN
        e = ref_md(3'd3, 32'd10, 32'd3);
        op = 3'd3;
`else
        e = ref_md(3'd1, 32'd10, 32'd3);
        op = 3'd1;
`endif
        opa = 32'd10; opb = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; ok = 1'b1;
        while (lat < 60) begin
            if (lat == 4) begin
                op = 3'd1; opa = 32'd2; opb = 32'd2; start = 1'b1;
            end
            if (lat == 5) start = 1'b0;
            @(negedge clk);
            lat++;
            if (done === 1'b1) break;
            if (busy !== 1'b1 || hi !== mhi || lo !== mlo) ok = 1'b0;
        end
        total++;
        if (lat !== 32 || !ok || hi !== e[63:32] || lo !== e[31:0]) begin
            bad++; $display("FAIL ignore_start: got lat=%0d hold_ok=%0d hi=%h lo=%h want lat=32 hold_ok=1 hi=%h lo=%h",
                            lat, ok, hi, lo, e[63:32], e[31:0]);
        end
        mhi = e[63:32]; mlo = e[31:0];
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL ignore_start idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit ok;
        logic [31:0] a1, b1, a2, b2;
        logic [63:0] e1, e2;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        e1 = ref_md(3'd1, a1, b1);
        e2 = ref_md(3'd0, a2, b2);
        op = 3'd1; opa = a1; opb = b1; start = 1'b1;
        @(negedge clk);
        op = 3'd0; opa = a2; opb = b2;
        wait_done(mhi, mlo, lat, ok);
        total++;
        if (lat !== 32 || !ok || hi !== e1[63:32] || lo !== e1[31:0]) begin
            bad++; $display("FAIL b2b first: got lat=%0d hi=%h lo=%h want lat=32 hi=%h lo=%h",
                            lat, hi, lo, e1[63:32], e1[31:0]);
        end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL b2b reaccept: got busy=%b done=%b want 1 0", busy, done);
        end
        wait_done(e1[63:32], e1[31:0], lat, ok);
        total++;
        if (lat !== 32 || !ok || hi !== e2[63:32] || lo !== e2[31:0]) begin
            bad++; $display("FAIL b2b second: got lat=%0d hold_ok=%0d hi=%h lo=%h want lat=32 hold_ok=1 hi=%h lo=%h",
                            lat, ok, hi, lo, e2[63:32], e2[31:0]);
        end
        mhi = e2[63:32]; mlo = e2[31:0];
        @(negedge clk);
    endtask

    task automatic test_flush();
        bit seen_done;
        do_mt(3'd4, 32'hAAAA_AAAA, "pre_mthi");
        do_mt(3'd5, 32'h5555_5555, "pre_mtlo");
        op = 3'd0; opa = 32'd1234; opb = 32'hFFFF_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'hAAAA_AAAA || lo !== 32'h5555_5555) begin
            bad++; $display("FAIL flush_run: got busy=%b done=%b hi=%h lo=%h want 0 0 aaaaaaaa 55555555",
                            busy, done, hi, lo);
        end
        seen_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
        end
        total++;
        if (seen_done) begin
            bad++; $display("FAIL flush_quiet: got late busy/done=1 want 0");
        end
        // Flush in IDLE swallows the Start that accompanies it.
        flush = 1'b1; op = 3'd4; opa = 32'hDEAD_BEEF; start = 1'b1;
        @(negedge clk);
        op = 3'd1; opa = 32'd3; opb = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        total++;
        if (busy !== 1'b0 || hi !== mhi || lo !== mlo) begin
            bad++; $display("FAIL flush_idle: got busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h",
                            busy, hi, lo, mhi, mlo);
        end
    endtask

    task automatic test_reset_mid_run();
        op = 3'd0; opa = 32'hAAAA_AAAA; opb = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_mid_run: got hi=%h lo=%h busy=%b done=%b want all 0", hi, lo, busy, done);
        end
        mhi = 32'd0; mlo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_release: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_random();
        logic [2:0] o;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 5));
`ifndef MDU_DIV_EN
            if (o == 3'd2 || o == 3'd3) o = o - 3'd2;
`endif
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            if (o >= 3'd4) do_mt(o, a, "rand_mt");
            else do_md(o, a, b, "rand_md");
        end
    endtask

    initial begin
        test_reset();
        test_mul();
`ifdef MDU_DIV_EN
        test_div();
`else
        test_no_div();
`endif
        test_reserved();
        test_busy_ignore();
        test_back_to_back();
        test_flush();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
